pipe_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU. It accepts one request at a time and drives the memory-side request/ready handshake. It returns read data with a one-cycle valid pulse and produces per-stage stall signals for the hazard/pipeline-register logic. MEM has priority over IF, and a streak counter bounds IF starvation.

---
 rtl/pipe_mem_arbiter.sv | 117 +++++++++++
 tb/tb_pipe_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter between the IF and MEM pipeline stages.
// MEM has priority; a streak counter forces an IF grant after MAX_MEM_STREAK MEM grants.
module pipe_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_MEM,
    BUSY_IF,
    DONE_MEM,
    DONE_IF
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_MEM_STREAK);

  state_t     state_reg;
  logic [3:0] streak_reg;
  logic       mem_pend;
  logic       if_forced;

  assign mem_pend  = mem_rd | mem_wr;
  assign if_forced = if_req && (streak_reg == MAX_S);

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = mem_pend & ~mem_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      streak_reg <= 4'd0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      mem_valid  <= 1'b0;
      mem_rdata  <= '0;
      proto_err  <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_pend && !if_forced) begin
            state_reg <= BUSY_MEM;
            ram_req   <= 1'b1;
            // A simultaneous read+write is resolved as a write
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            if (mem_rd && mem_wr) proto_err <= 1'b1;
            if (if_req)
              streak_reg <= (streak_reg == MAX_S) ? MAX_S : streak_reg + 4'd1;
            else
              streak_reg <= 4'd0;
          end else if (if_req) begin
            state_reg  <= BUSY_IF;
            ram_req    <= 1'b1;
            ram_we     <= 1'b0;
            ram_addr   <= if_addr;
            ram_wdata  <= '0;
            streak_reg <= 4'd0;
          end
        end
        BUSY_MEM: begin
          if (ram_ready) begin
            state_reg <= DONE_MEM;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            mem_rdata <= ram_we ? '0 : ram_rdata;
            mem_valid <= 1'b1;
          end
        end
        BUSY_IF: begin
          if (ram_ready) begin
            state_reg <= DONE_IF;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            if_rdata  <= ram_rdata;
            if_valid  <= 1'b1;
          end
        end
        // Requester still shows req during DONE, so no grant is made here
        DONE_MEM: state_reg <= IDLE;
        DONE_IF:  state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter; inputs driven and outputs
// sampled on the falling clock edge.
module tb_pipe_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              proto_err;

  int checks = 0;
  int errors = 0;

  pipe_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_MEM_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
    mem_addr = 0; mem_wdata = 0; ram_rdata = 0; ram_ready = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ram_req, ram_we, if_valid, mem_valid, proto_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 00000", {ram_req, ram_we, if_valid, mem_valid, proto_err});
    end
    checks++;
    if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {ram_addr, ram_wdata, if_rdata, mem_rdata});
    end
    // Stray ready with no request must be ignored
    ram_ready = 1'b1; ram_rdata = 32'h12345678;
    tick();
    ram_ready = 1'b0;
    tick();
    checks++;
    if ({ram_req, if_valid, mem_valid} !== 3'b0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL stray_ready: got req/ifv/memv=%b if_rdata=%h required 000/0", {ram_req, if_valid, mem_valid}, if_rdata);
    end
    $display("txn reset: done");
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h00400000;
    #1;
    checks++;
    if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall0: got %b required 1", stall_if); end
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h00400000 || stall_if !== 1'b1) begin
      errors++; $display("FAIL fetch_busy: got req=%b we=%b addr=%h stall=%b required 1 0 00400000 1", ram_req, ram_we, ram_addr, stall_if);
    end
    ram_ready = 1'b1; ram_rdata = 32'h20080005;
    tick();
    checks++;
    if (ram_req !== 1'b0 || if_valid !== 1'b1 || if_rdata !== 32'h20080005 || stall_if !== 1'b0) begin
      errors++; $display("FAIL fetch_done: got req=%b valid=%b rdata=%h stall=%b required 0 1 20080005 0", ram_req, if_valid, if_rdata, stall_if);
    end
    ram_ready = 1'b0; ram_rdata = 32'hFFFFFFFF; if_req = 1'b0;
    tick();
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h20080005) begin
      errors++; $display("FAIL fetch_pulse: got valid=%b rdata=%h required 0 20080005", if_valid, if_rdata);
    end
    $display("txn fetch: addr=00400000 rdata=%h", if_rdata);
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h00400004;
    mem_rd = 1'b1; mem_addr = 32'h10010000;
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h10010000 || stall_if !== 1'b1 || stall_mem !== 1'b1) begin
      errors++; $display("FAIL simul_mem_first: got req=%b we=%b addr=%h sif=%b smem=%b required 1 0 10010000 1 1", ram_req, ram_we, ram_addr, stall_if, stall_mem);
    end
    ram_ready = 1'b1; ram_rdata = 32'hCAFE0001;
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_rdata !== 32'hCAFE0001 || stall_if !== 1'b1 || stall_mem !== 1'b0) begin
      errors++; $display("FAIL simul_mem_done: got valid=%b rdata=%h sif=%b smem=%b required 1 cafe0001 1 0", mem_valid, mem_rdata, stall_if, stall_mem);
    end
    ram_ready = 1'b0; mem_rd = 1'b0;
    tick();
    checks++;
    if (ram_req !== 1'b0 || stall_if !== 1'b1) begin
      errors++; $display("FAIL simul_idle: got req=%b sif=%b required 0 1", ram_req, stall_if);
    end
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h00400004 || stall_if !== 1'b1) begin
      errors++; $display("FAIL simul_if_grant: got req=%b addr=%h sif=%b required 1 00400004 1", ram_req, ram_addr, stall_if);
    end
    ram_ready = 1'b1; ram_rdata = 32'h00000013;
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00000013) begin
      errors++; $display("FAIL simul_if_done: got valid=%b rdata=%h required 1 00000013", if_valid, if_rdata);
    end
    ram_ready = 1'b0; if_req = 1'b0;
    $display("txn simultaneous: mem then if");
  endtask

  task automatic test_starvation();
    bit got_req;
    do_reset();
    if_req = 1'b1; if_addr = 32'h00400100;
    mem_rd = 1'b1; mem_addr = 32'h10010100;
    for (int i = 0; i < 10; i++) begin
      got_req = 1'b0;
      for (int w = 0; w < 10 && !got_req; w++) begin
        if (ram_req === 1'b1) got_req = 1'b1;
        else tick();
      end
      checks++;
      if (!got_req) begin
        errors++; $display("FAIL starve_timeout: grant %0d never issued", i);
      end else begin
        checks++;
        if (ram_addr !== ((i % 5 == 4) ? 32'h00400100 : 32'h10010100)) begin
          errors++; $display("FAIL starve_order: grant %0d addr=%h required %h", i, ram_addr, (i % 5 == 4) ? 32'h00400100 : 32'h10010100);
        end
        $display("txn starve grant %0d: addr=%h", i, ram_addr);
        ram_ready = 1'b1; ram_rdata = 32'h0;
        tick();
        ram_ready = 1'b0;
      end
    end
    if_req = 1'b0; mem_rd = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store_wait();
    do_reset();
    mem_wr = 1'b1; mem_addr = 32'h10010004; mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h10010004 || ram_wdata !== 32'hDEADBEEF) begin
        errors++; $display("FAIL store_hold%0d: got req=%b we=%b addr=%h wdata=%h required 1 1 10010004 deadbeef", c, ram_req, ram_we, ram_addr, ram_wdata);
      end
      // Requester inputs wander while busy; the latched values must not follow
      mem_addr = 32'h0BAD0000 + c; mem_wdata = 32'h55550000 + c;
    end
    ram_ready = 1'b1; ram_rdata = 32'hA5A5A5A5;
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_rdata !== 32'h0 || ram_req !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL store_done: got valid=%b rdata=%h req=%b we=%b required 1 0 0 0", mem_valid, mem_rdata, ram_req, ram_we);
    end
    ram_ready = 1'b0; mem_wr = 1'b0;
    tick();
    $display("txn store: addr=10010004 wdata=deadbeef");
  endtask

  task automatic test_proto_err();
    bit got_req;
    do_reset();
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h10010008; mem_wdata = 32'h0000BEEF;
    tick();
    checks++;
    if (ram_we !== 1'b1 || proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_set: got we=%b err=%b required 1 1", ram_we, proto_err);
    end
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if_req = 1'b1; if_addr = 32'h00400000 + 4 * i;
      got_req = 1'b0;
      for (int w = 0; w < 10 && !got_req; w++) begin
        tick();
        if (ram_req === 1'b1) got_req = 1'b1;
      end
      if (!got_req) begin
        checks++; errors++; $display("FAIL proto_txn_timeout: fetch %0d never granted", i);
      end
      ram_ready = 1'b1;
      tick();
      ram_ready = 1'b0; if_req = 1'b0;
    end
    tick();
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b required 1", proto_err); end
    do_reset();
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b required 0", proto_err); end
    $display("txn proto_err: sticky over 10 fetches");
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    if_req = 1'b1; if_addr = 32'h00400040;
    tick();
    checks++;
    if (ram_req !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b required 1", ram_req); end
    reset = 1'b1;
    tick();
    checks++;
    if (ram_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got req=%b valid=%b required 0 0", ram_req, if_valid);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h00400040 || if_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_regrant: got req=%b addr=%h valid=%b required 1 00400040 0", ram_req, ram_addr, if_valid);
    end
    ram_ready = 1'b1; ram_rdata = 32'h8C820000;
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h8C820000) begin
      errors++; $display("FAIL midrst_done: got valid=%b rdata=%h required 1 8c820000", if_valid, if_rdata);
    end
    ram_ready = 1'b0; if_req = 1'b0;
    $display("txn reset_mid_op: regranted addr=00400040");
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
    mem_addr = 0; mem_wdata = 0; ram_rdata = 0; ram_ready = 0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store_wait();
    test_proto_err();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
